// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl
// Time-multiplexed scan controller for a multi-digit 7-segment display that
// shares a single BCD-to-7-segment decoder. Display data is double-buffered:
// a shadow register collects loads, and the active register only changes at a
// frame boundary, so a frame never shows a mix of old and new digits.
// Outputs are decoded from registered state (plus the blank_lz input) only.

module seg_scan_ctrl #(
   parameter int NUM_DIGITS = 4,
   parameter int SCAN_DIV   = 16,
   parameter int GUARD      = 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    en,
   input  logic                    load,
   input  logic [4*NUM_DIGITS-1:0] data,
   input  logic                    blank_lz,
   output logic [3:0]              dec_i,
   output logic [NUM_DIGITS-1:0]   an_n,
   output logic                    frame_tick,
   output logic                    pending
);

   localparam int DIV_W = $clog2(SCAN_DIV);
   localparam int IDX_W = $clog2(NUM_DIGITS);

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
   localparam logic [DIV_W-1:0] GUARD_V  = DIV_W'(GUARD);

   typedef enum logic [0:0] {
      ST_OFF  = 1'b0,
      ST_SCAN = 1'b1
   } state_t;

   state_t                  st;
   state_t                  next_st;
   logic [DIV_W-1:0]        div;
   logic [DIV_W-1:0]        next_div;
   logic [IDX_W-1:0]        idx;
   logic [IDX_W-1:0]        next_idx;
   logic [4*NUM_DIGITS-1:0] shadow;
   logic [4*NUM_DIGITS-1:0] active;
   logic                    at_boundary;
   logic [NUM_DIGITS-1:0]   blanked;
   logic                    all_zero;
   logic [3:0]              cur_digit;

   // Last cycle of the last digit slot of a frame.
   assign at_boundary = (st == ST_SCAN) && (idx == IDX_LAST) && (div == DIV_LAST);

   // Scan state register: state, slot divider and digit index.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         st  <= ST_OFF;
         div <= {DIV_W{1'b0}};
         idx <= {IDX_W{1'b0}};
      end else begin
         st  <= next_st;
         div <= next_div;
         idx <= next_idx;
      end
   end

   // Next-state logic: step div every cycle, idx every slot, drop to OFF when disabled.
   always_comb begin
      next_st  = st;
      next_div = div;
      next_idx = idx;
      case (st)
         ST_OFF: begin
            next_div = {DIV_W{1'b0}};
            next_idx = {IDX_W{1'b0}};
            if (en) begin
               next_st = ST_SCAN;
            end else begin
               next_st = ST_OFF;
            end
         end
         ST_SCAN: begin
            if (!en) begin
               next_st  = ST_OFF;
               next_div = {DIV_W{1'b0}};
               next_idx = {IDX_W{1'b0}};
            end else begin
               next_st = ST_SCAN;
               if (div == DIV_LAST) begin
                  next_div = {DIV_W{1'b0}};
                  if (idx == IDX_LAST) begin
                     next_idx = {IDX_W{1'b0}};
                  end else begin
                     next_idx = idx + IDX_W'(1);
                  end
               end else begin
                  next_div = div + DIV_W'(1);
                  next_idx = idx;
               end
            end
         end
         default: begin
            next_st  = ST_OFF;
            next_div = {DIV_W{1'b0}};
            next_idx = {IDX_W{1'b0}};
         end
      endcase
   end

   // Double buffer: loads land in shadow; active changes only at a frame
   // boundary or while idle. A load in the boundary cycle goes straight to active.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shadow  <= {4*NUM_DIGITS{1'b0}};
         active  <= {4*NUM_DIGITS{1'b0}};
         pending <= 1'b0;
      end else if (at_boundary) begin
         if (load) begin
            active  <= data;
            shadow  <= data;
            pending <= 1'b0;
         end else if (pending) begin
            active  <= shadow;
            pending <= 1'b0;
         end
      end else if (st == ST_OFF) begin
         if (pending) begin
            active <= shadow;
         end
         if (load) begin
            shadow  <= data;
            pending <= 1'b1;
         end else begin
            pending <= 1'b0;
         end
      end else begin
         if (load) begin
            shadow  <= data;
            pending <= 1'b1;
         end
      end
   end

   // Leading-zero mask: digit k blanks when it and every digit above it are zero.
   always_comb begin
      blanked  = {NUM_DIGITS{1'b0}};
      all_zero = 1'b1;
      for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
         all_zero   = all_zero & (active[4*k +: 4] == 4'h0);
         blanked[k] = blank_lz & all_zero;
      end
   end

   // BCD code of the digit currently being scanned.
   assign cur_digit = active[{idx, 2'b00} +: 4];

   // Output decode: one anode low outside the guard window unless blanked.
   always_comb begin
      an_n       = {NUM_DIGITS{1'b1}};
      dec_i      = 4'hF;
      frame_tick = 1'b0;
      if (st == ST_SCAN) begin
         frame_tick = at_boundary;
         if ((div >= GUARD_V) && !blanked[idx]) begin
            an_n[idx] = 1'b0;
            dec_i     = cur_digit;
         end else begin
            an_n  = {NUM_DIGITS{1'b1}};
            dec_i = 4'hF;
         end
      end else begin
         an_n       = {NUM_DIGITS{1'b1}};
         dec_i      = 4'hF;
         frame_tick = 1'b0;
      end
   end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl
// Directed bench for seg_scan_ctrl (4 digits, 8-cycle slots, 1-cycle guard).
// Stimulus pushes the expected per-cycle outputs into a queue; a monitor on
// the falling edge pops each entry and compares it with the DUT outputs.

module tb_seg_scan_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        en = 1'b0;
   logic        load = 1'b0;
   logic [15:0] data = 16'h0000;
   logic        blank_lz = 1'b0;
   logic [3:0]  dec_i;
   logic [3:0]  an_n;
   logic        frame_tick;
   logic        pending;

   seg_scan_ctrl #(
      .NUM_DIGITS (4),
      .SCAN_DIV   (8),
      .GUARD      (1)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .load       (load),
      .data       (data),
      .blank_lz   (blank_lz),
      .dec_i      (dec_i),
      .an_n       (an_n),
      .frame_tick (frame_tick),
      .pending    (pending)
   );

   // 10-unit clock period.
   always #5 clk = ~clk;

   typedef struct packed {
      logic [3:0] an;
      logic [3:0] dec;
      logic       tick;
      logic       pend;
      logic [7:0] ph;
      logic [7:0] cyc;
   } exp_t;

   exp_t q[$];
   exp_t mon_e;
   int   checks = 0;
   int   errors = 0;
   int   phase  = 0;

   // Monitor: compare DUT outputs against the oldest queued expectation.
   always @(negedge clk) begin
      if (q.size() > 0) begin
         mon_e = q.pop_front();
         checks++;
         if ({an_n, dec_i, frame_tick, pending} !== {mon_e.an, mon_e.dec, mon_e.tick, mon_e.pend}) begin
            errors++;
            $display("FAIL slot phase=%0d cyc=%0d: got an_n=%b dec_i=%h tick=%b pend=%b, want an_n=%b dec_i=%h tick=%b pend=%b",
                     mon_e.ph, mon_e.cyc, an_n, dec_i, frame_tick, pending,
                     mon_e.an, mon_e.dec, mon_e.tick, mon_e.pend);
         end
      end
   end

   task automatic push_exp(input logic [3:0] a, input logic [3:0] d,
                           input logic t, input logic p, input int c);
      exp_t e;
      e.an   = a;
      e.dec  = d;
      e.tick = t;
      e.pend = p;
      e.ph   = 8'(phase);
      e.cyc  = 8'(c);
      q.push_back(e);
   endtask

   // Apply inputs after the falling edge, then queue the outputs expected
   // for the cycle that follows the next rising edge.
   task automatic step(input logic n_en, input logic n_load, input logic [15:0] n_data,
                       input logic n_blank, input logic [3:0] a, input logic [3:0] d,
                       input logic t, input logic p, input int c);
      @(negedge clk);
      #1;
      en       = n_en;
      load     = n_load;
      data     = n_data;
      blank_lz = n_blank;
      @(posedge clk);
      #1;
      push_exp(a, d, t, p, c);
   endtask

   // Scan n cycles of a frame showing val; vis marks which digits are lit.
   // ld is the frame cycle whose opening edge samples load (-1: no load).
   task automatic run_frame(input logic [15:0] val, input logic [3:0] vis, input logic blank,
                            input int ld, input logic [15:0] ldval, input int n);
      for (int c = 0; c < n; c++) begin
         int         slot;
         int         d;
         logic [3:0] a;
         logic [3:0] dd;
         slot = c / 8;
         d    = c % 8;
         if ((d == 0) || !vis[slot]) begin
            a  = 4'hF;
            dd = 4'hF;
         end else begin
            a  = ~(4'b0001 << slot);
            dd = val[slot*4 +: 4];
         end
         step(1'b1, (c == ld), ldval, blank, a, dd, (c == 31), ((ld >= 1) && (c >= ld)), c);
      end
   endtask

   initial begin
      // Reset state.
      phase = 0;
      step(1'b0, 1'b0, 16'h0000, 1'b0, 4'hF, 4'hF, 1'b0, 1'b0, 0);
      step(1'b0, 1'b0, 16'h0000, 1'b0, 4'hF, 4'hF, 1'b0, 1'b0, 1);
      rst = 1'b0;

      // Load while idle: pending for one edge, then copied to active.
      phase = 1;
      step(1'b0, 1'b1, 16'h1234, 1'b0, 4'hF, 4'hF, 1'b0, 1'b1, 0);
      step(1'b0, 1'b0, 16'h1234, 1'b0, 4'hF, 4'hF, 1'b0, 1'b0, 1);

      // Two full frames of 1234.
      phase = 2;
      run_frame(16'h1234, 4'hF, 1'b0, -1, 16'h0000, 32);
      run_frame(16'h1234, 4'hF, 1'b0, -1, 16'h0000, 32);

      // Mid-frame load during digit 1: old frame continues, new one shows 5678.
      phase = 3;
      run_frame(16'h1234, 4'hF, 1'b0, 10, 16'h5678, 32);
      run_frame(16'h5678, 4'hF, 1'b0, -1, 16'h0000, 32);

      // Load in the frame_tick cycle: bypasses shadow, pending never rises.
      phase = 4;
      run_frame(16'h9999, 4'hF, 1'b0, 0, 16'h9999, 32);
      run_frame(16'h9999, 4'hF, 1'b0, -1, 16'h0000, 32);

      // Leading-zero blanking.
      phase = 5;
      run_frame(16'h0070, 4'b0011, 1'b1, 0, 16'h0070, 32);
      run_frame(16'h0000, 4'b0001, 1'b1, 0, 16'h0000, 32);

      // Drop enable at idx=2, div=4, then restart from the top.
      phase = 6;
      run_frame(16'h1234, 4'hF, 1'b0, 0, 16'h1234, 21);
      step(1'b0, 1'b0, 16'h0000, 1'b0, 4'hF, 4'hF, 1'b0, 1'b0, 21);
      step(1'b0, 1'b0, 16'h0000, 1'b0, 4'hF, 4'hF, 1'b0, 1'b0, 22);
      step(1'b0, 1'b0, 16'h0000, 1'b0, 4'hF, 4'hF, 1'b0, 1'b0, 23);
      run_frame(16'h1234, 4'hF, 1'b0, -1, 16'h0000, 32);

      // Asynchronous reset mid-slot with a pending load.
      phase = 7;
      run_frame(16'h1234, 4'hF, 1'b0, 5, 16'hABCD, 13);
      @(negedge clk);
      #1;
      rst = 1'b1;
      push_exp(4'hF, 4'hF, 1'b0, 1'b0, 99);
      step(1'b1, 1'b0, 16'h0000, 1'b0, 4'hF, 4'hF, 1'b0, 1'b0, 100);
      step(1'b1, 1'b0, 16'h0000, 1'b0, 4'hF, 4'hF, 1'b0, 1'b0, 101);
      rst = 1'b0;
      run_frame(16'h0000, 4'hF, 1'b0, -1, 16'h0000, 32);

      // Every queued expectation must have been consumed.
      repeat (2) @(negedge clk);
      #1;
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d entries left, want 0", q.size());
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
- Time-multiplexed scan controller for a multi-digit 7-segment display that shares one BCD-to-7-segment decoder.
- Each frame, it steps through the digits in order. For each digit it drives that digit's BCD code to the decoder input and enables that digit's active-low anode.
- Display data is double-buffered: a new value takes effect only at a frame boundary, so a frame never shows a mix of old and new digits.
- Provides leading-zero blanking, an inter-digit guard gap against ghosting, and a per-frame tick.

Parameters:
- NUM_DIGITS, 4, number of digits scanned (2..8).
- SCAN_DIV, 16, clock cycles per digit slot (≥2).
- GUARD, 1, cycles at the start of each slot with all anodes off (0 ≤ GUARD < SCAN_DIV).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- en  in  1  scan enable. 0 forces the OFF state.
- load  in  1  single-cycle pulse that captures `data` into the shadow register.
- data  in  4*NUM_DIGITS  BCD digits; bits [3:0] = digit 0 (least significant).
- blank_lz  in  1  leading-zero blanking enable.
- dec_i  out  4  BCD code to the shared decoder; 4'hF when blank.
- an_n  out  NUM_DIGITS  active-low digit enables, one-hot-low or all-ones.
- frame_tick  out  1  one-cycle pulse on the last cycle of each frame.
- pending  out  1  shadow data is waiting for the next frame boundary.

Behaviour:
- Reset (async, any time):
  - State = OFF; div = 0; idx = 0; shadow = 0; active = 0; pending = 0.
  - Outputs: an_n = all 1s, dec_i = 4'hF, frame_tick = 0.
- Outputs are combinational functions of registered state only (st, div, idx, active, blank_lz). No input-to-output combinational path except blank_lz.
- States:
  - OFF: div and idx held at 0; an_n all 1s; dec_i = 4'hF.
    - If en=1 at a clock edge: go to SCAN with div = 0, idx = 0.
    - While in OFF, a pending shadow is copied to active (and pending cleared) on every edge.
  - SCAN:
    - div increments each cycle. At div = SCAN_DIV-1, div wraps to 0 and idx increments.
    - idx wraps from NUM_DIGITS-1 to 0.
    - en=0 at an edge: go to OFF immediately, with div = 0 and idx = 0. Any partial frame is abandoned and no frame_tick is generated.
- Frame boundary = SCAN state with idx = NUM_DIGITS-1 and div = SCAN_DIV-1. frame_tick = 1 exactly in that cycle.
- Load and transfer:
  - load=1 alone: shadow ← data; pending ← 1.
  - At a frame boundary edge with pending=1: active ← shadow; pending ← 0.
  - load=1 in the frame-boundary cycle: active ← data (the new value, bypassing shadow); shadow ← data; pending stays 0.
  - Repeated loads before a boundary: the last one wins.
- Blanking of digit k:
  - Blanked if blank_lz=1, k ≠ 0, and active digits k..NUM_DIGITS-1 are all 0.
  - Digit 0 is never blanked by this rule.
- Slot output for the current digit idx:
  - If div < GUARD, or the digit is blanked: an_n = all 1s, dec_i = 4'hF.
  - Otherwise: an_n[idx] = 0 (all other bits 1), dec_i = active digit idx.
- Digit codes 10..15 pass through unchanged; the decoder renders them dark. The anode is still enabled for such a digit.
- Frame length = NUM_DIGITS*SCAN_DIV cycles.
- No more than one an_n bit is ever low at a time.

Test Plan:
Bench parameters: NUM_DIGITS=4, SCAN_DIV=8, GUARD=1.
- Reset, then en=1, load data=16'h1234, wait 2 frames. Each 8-cycle slot: cycle 0 all anodes off; cycles 1-7 an_n=4'b1110/dec_i=4, then 1101/3, 1011/2, 0111/1. frame_tick high every 32nd cycle.
- Mid-frame load 16'h5678 at idx=1: the current frame keeps showing 1234 and pending=1 until the boundary. The next frame shows 8,7,6,5 and pending=0.
- load 16'h9999 in the exact frame_tick cycle: the next frame shows 9s; pending stays 0 throughout.
- blank_lz=1, data=16'h0070: digits 3 and 2 have an_n all 1s and dec_i=F; digit 1 shows 7; digit 0 shows 0. data=16'h0000 → only digit 0 lit, showing 0.
- Drop en at idx=2, div=4: OFF next cycle, an_n=4'hF, no frame_tick. Re-enable: scan restarts at idx=0, div=0.
- Assert rst mid-slot with pending=1: outputs go to reset values immediately and pending=0. After release with en=1, the display shows 0000.
